rr_arbiter_4ch: RTL and testbench
=================================

# rr_arbiter_4ch

Four-channel round-robin arbiter. It sits directly upstream of the 2-to-4 decoder and drives the decoder's enable and 2-bit select, so the decoder output becomes a one-hot grant vector. The arbiter holds each grant until the requester releases it or a hold limit expires. It always inserts one idle cycle between grants (break-before-make), so the decoder output is never one-hot on two different lines in back-to-back cycles.

## Interface
Parameters:
- HOLD_MAX, default 8: maximum number of cycles a single grant may stay asserted (legal range 1..15).
- CNT_W, default 4: width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  the single clock; everything is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = channel i requests.
- done  input  1  the granted channel releases its grant this cycle.
- En  output  1  grant valid; drives the decoder's En input.
- W  output  2  granted channel index; drives the decoder's W input.
- busy  output  1  high while the arbiter is in GRANT or GAP.
- timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

## Operation
- State machine states: IDLE, GRANT, GAP.
- Internal state: 2-bit pointer ptr and hold counter cnt.
- Pick rule: the first channel with req set, searching ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE: if req is nonzero, load W with the picked channel, set En=1, clear cnt, go to GRANT. Otherwise stay in IDLE with En=0.
- GRANT: En=1 and W holds steady; cnt increments each cycle.
- GRANT exit conditions, any of the following:
  - done=1;
  - req[W]=0 (silent release);
  - cnt == HOLD_MAX-1 (forced release).
- GRANT exit actions: En=0, ptr=W+1 mod 4 (wrapping 3→0), go to GAP.
- timeout=1 for exactly the exit cycle, and only when the exit is forced and neither done nor a silent release occurred that same cycle. If done coincides with the limit, done wins and timeout stays 0.
- GAP: En=0 for exactly one cycle, and W keeps its last value.
  - If req is nonzero, pick using the updated ptr and go to GRANT.
  - Otherwise go to IDLE.
- A re-request from the just-released channel is granted again only if no other channel requests.
- req changes on non-granted bits during GRANT are ignored.

## Timing
- All outputs are registered; there is no combinational path from req or done to any output.
- Reset values: En=0, W=2'b00, busy=0, timeout=0, ptr=0, cnt=0, state IDLE.
- rst mid-GRANT forces the reset values on the next edge, with no timeout pulse.
- Grant latency: req sampled nonzero in IDLE at edge n gives En=1 after edge n.
- Release latency: done sampled at edge m gives En=0 after edge m.
  - If a request is pending, the next grant appears after edge m+1 (exactly one gap cycle).
- Minimum grant length is 1 cycle (done asserted in the first grant cycle).
- Maximum grant length is HOLD_MAX cycles.
- busy follows the registered state: 1 in GRANT and GAP, 0 in IDLE.

## Structure
- Shared package holds:
  - state encodings: IDLE=2'd0, GRANT=2'd1, GAP=2'd2;
  - the channel count constant (4);
  - the index width constant (2).
- One natural sub-module, rr_pick4: purely combinational.
  - Inputs: req[3:0] and ptr[1:0].
  - Outputs: found and idx[1:0].
  - Instantiated once, shared by the IDLE and GAP transitions.
- Top level holds the FSM, ptr, cnt and output registers.
- The top level instantiates alongside the decoder; it does not contain the decoder.

## Test plan
- Reset: rst=1 for 2 cycles with req=4'b1111 → En=0, W=0, busy=0, timeout=0 throughout; first grant after release is W=0.
- Single request: req=4'b0100 from IDLE → En=1, W=2 one edge later; done pulse → En=0 next edge, then busy=0 (IDLE) one edge after that.
- Rotation: req=4'b1111 held, done asserted on the first cycle of each grant → W sequence 0,1,2,3,0, each 1 cycle with En=1, separated by exactly one En=0 cycle.
- Timeout: HOLD_MAX=8, req=4'b0010 held, done=0 → En=1, W=1 for exactly 8 cycles; timeout=1 on the edge En drops; one gap cycle; W=1 granted again.
- Silent release and coincidence:
  - Granted W=3, req drops to 4'b0001 without done → release, gap, then W=0.
  - done together with the cnt limit → timeout stays 0.
- Reset mid-grant: W=3 granted, rst=1 for one cycle → En=0, W=0 after that edge; with req=4'b1111, the next grant is W=0.

Source files
------------

// File: rtl/rr_arbiter_4ch_pkg.sv
// ---------------------------------------------------------------------------
// rr_arbiter_4ch_pkg
//   Shared constants for the four-channel round-robin arbiter:
//   channel count, channel index width, FSM state encodings and a small
//   helper that advances the round-robin pointer.
// ---------------------------------------------------------------------------
package rr_arbiter_4ch_pkg;

  // Number of requesting channels and the width of a channel index.
  localparam int NUM_CH = 4;
  localparam int IDX_W  = 2;

  // FSM state encodings. These are plain constants rather than an enum so
  // the values stay fixed for any tool or legacy code that decodes them.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Channel after idx, wrapping 3 -> 0. The 2-bit result wraps for free.
  function automatic logic [IDX_W-1:0] next_ch(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage : rr_arbiter_4ch_pkg

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
//   Purely combinational round-robin picker. It returns the first requesting
//   channel found when searching ptr, ptr+1, ptr+2, ptr+3 (all mod 4).
//
// Ports
//   req_i   [3:0]  request vector, bit i = channel i requests
//   ptr_i   [1:0]  channel with the highest priority for this pick
//   found_o        at least one request is set
//   idx_o   [1:0]  picked channel (0 when found_o is low)
// ---------------------------------------------------------------------------
module rr_pick4
  import rr_arbiter_4ch_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic              found_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Rotate the request vector so that bit 0 is the pointer's channel; the
  // search then becomes a plain lowest-set-bit priority encode.
  logic [NUM_CH-1:0] rot;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
    assign rot[gi] = req_i[ptr_i + IDX_W'(gi)];
  end

  logic [IDX_W-1:0] offset;

  always_comb begin
    offset = '0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        offset = IDX_W'(k);
      end
    end
  end

  assign found_o = |rot;
  // Undo the rotation; 2-bit addition wraps back into channel space.
  assign idx_o   = found_o ? (ptr_i + offset) : '0;

endmodule : rr_pick4

// File: rtl/rr_arbiter_4ch.sv
// ---------------------------------------------------------------------------
// rr_arbiter_4ch
//   Four-channel round-robin arbiter feeding a 2-to-4 decoder (En / W).
//   A grant is held until the owner asserts done, drops its request, or the
//   grant has lasted HOLD_MAX cycles. Every grant is followed by exactly one
//   idle (GAP) cycle so the decoder never switches lines back-to-back.
//
// Parameters
//   HOLD_MAX  maximum grant length in cycles (1..15)
//   CNT_W     hold counter width, 2**CNT_W must exceed HOLD_MAX
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   req [3:0] request vector
//   done      granted channel releases its grant this cycle
//   En        grant valid (decoder enable)
//   W   [1:0] granted channel index (decoder select)
//   busy      arbiter is in GRANT or GAP
//   timeout   one-cycle pulse when a grant is revoked by the hold limit
// ---------------------------------------------------------------------------
module rr_arbiter_4ch
  import rr_arbiter_4ch_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              done,
  output logic              En,
  output logic [IDX_W-1:0]  W,
  output logic              busy,
  output logic              timeout
);

  // ------------------------------------------------------------------
  // State and output registers
  // ------------------------------------------------------------------
  logic [1:0]       state_q,   state_d;
  logic [IDX_W-1:0] ptr_q,     ptr_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             en_q,      en_d;
  logic [IDX_W-1:0] w_q,       w_d;
  logic             busy_q,    busy_d;
  logic             timeout_q, timeout_d;

  // ------------------------------------------------------------------
  // Shared picker: used both from IDLE and from GAP. In GAP the pointer
  // has already been advanced past the channel that just released.
  // ------------------------------------------------------------------
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  rr_pick4 u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // ------------------------------------------------------------------
  // Grant exit conditions, evaluated against the current owner w_q.
  // cnt_q counts grant cycles from 0, so reaching HOLD_MAX-1 means this
  // is the HOLD_MAX-th cycle with En high.
  // ------------------------------------------------------------------
  logic owner_req;
  logic at_limit;
  logic grant_exit;

  assign owner_req  = req[w_q];
  assign at_limit   = (cnt_q == CNT_W'(HOLD_MAX - 1));
  assign grant_exit = done | ~owner_req | at_limit;

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    w_d       = w_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        en_d = 1'b0;
        if (pick_found) begin
          w_d     = pick_idx;
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        en_d  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (grant_exit) begin
          en_d    = 1'b0;
          ptr_d   = next_ch(w_q);
          state_d = ST_GAP;
          // Only a pure hold-limit release is a timeout; an explicit or
          // silent release in the same cycle takes precedence.
          timeout_d = at_limit & ~done & owner_req;
        end
      end

      ST_GAP: begin
        // W keeps its last value through the gap cycle.
        en_d = 1'b0;
        if (pick_found) begin
          w_d     = pick_idx;
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // busy is registered alongside the state so it mirrors the state register.
  assign busy_d = (state_d != ST_IDLE);

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      w_q       <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      w_q       <= w_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign En      = en_q;
  assign W       = w_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule : rr_arbiter_4ch

// File: tb/tb_rr_arbiter_4ch.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_4ch
//   Scoreboard bench for rr_arbiter_4ch. The stimulus process drives inputs
//   on the falling edge, advances a behavioural reference model and queues
//   the outputs expected after the next rising edge. A separate monitor
//   pops one entry per rising edge and compares all four outputs.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_4ch;

  localparam int HOLD_MAX = 8;
  localparam int CNT_W    = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       En;
  logic [1:0] W;
  logic       busy;
  logic       timeout;

  rr_arbiter_4ch #(
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .En      (En),
    .W       (W),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic [1:0] w;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  bit   active   = 0;

  // ------------------------------------------------------------------
  // Reference model: who owns the bus, how long it has held it, whether
  // the bus is resting after a release, and which channel is first in
  // line for the next search.
  // ------------------------------------------------------------------
  bit m_owned = 0;
  bit m_gap   = 0;
  int m_owner = 0;
  int m_held  = 0;
  int m_first = 0;
  bit m_to    = 0;

  task automatic model_step(input bit r, input logic [3:0] rq, input bit d);
    bit limit;
    bit silent;
    m_to = 0;
    if (r) begin
      m_owned = 0;
      m_gap   = 0;
      m_owner = 0;
      m_held  = 0;
      m_first = 0;
    end else if (m_owned) begin
      // m_held = number of cycles the owner has already seen En high,
      // including the current one.
      limit  = (m_held == HOLD_MAX);
      silent = (rq[m_owner] == 1'b0);
      if (d || silent || limit) begin
        m_to    = limit && !d && !silent;
        m_owned = 0;
        m_gap   = 1;
        m_first = (m_owner + 1) % 4;
      end else begin
        m_held = m_held + 1;
      end
    end else begin
      m_gap = 0;
      for (int k = 0; k < 4; k++) begin
        if (!m_owned && rq[(m_first + k) % 4]) begin
          m_owner = (m_first + k) % 4;
          m_owned = 1;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic drive(input bit r, input logic [3:0] rq, input bit d);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = d;
    model_step(r, rq, d);
    e.en   = m_owned;
    e.w    = 2'(m_owner);
    e.busy = m_owned || m_gap;
    e.to   = m_to;
    sb.push_back(e);
    active = 1;
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cycle, act, exp_v);
    end
  endtask

  // ------------------------------------------------------------------
  // Monitor
  // ------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("En",      int'(En),      int'(e.en));
        chk("W",       int'(W),       int'(e.w));
        chk("busy",    int'(busy),    int'(e.busy));
        chk("timeout", int'(timeout), int'(e.to));
        $display("cyc=%0d En=%0b W=%0d busy=%0b timeout=%0b", cycle, En, W, busy, timeout);
      end else if (active) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow cycle=%0d actual=empty required=entry", cycle);
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  initial begin
    logic [3:0] r_req;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;

    // Reset with all channels requesting; first grant must be channel 0.
    drive(1, 4'b1111, 0);
    drive(1, 4'b1111, 0);
    drive(0, 4'b1111, 0);
    drive(0, 4'b0000, 1);
    drive(0, 4'b0000, 0);
    drive(0, 4'b0000, 0);

    // Single request, done pulse, then back to idle.
    drive(0, 4'b0100, 0);
    drive(0, 4'b0000, 1);
    drive(0, 4'b0000, 0);
    drive(0, 4'b0000, 0);

    // Rotation 0,1,2,3,0 with one-cycle grants.
    drive(1, 4'b0000, 0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'b1111, 0);
      drive(0, 4'b1111, 1);
    end
    drive(0, 4'b0000, 0);
    drive(0, 4'b0000, 0);

    // Hold-limit timeout on channel 1, followed by a re-grant.
    for (int i = 0; i < 2 * HOLD_MAX + 4; i++) drive(0, 4'b0010, 0);
    drive(0, 4'b0000, 0);
    drive(0, 4'b0000, 0);

    // Silent release of channel 3, then done coinciding with the limit.
    drive(1, 4'b0000, 0);
    drive(0, 4'b1000, 0);
    drive(0, 4'b0001, 0);
    drive(0, 4'b0001, 0);
    for (int i = 0; i < HOLD_MAX - 1; i++) drive(0, 4'b0001, 0);
    drive(0, 4'b0001, 1);
    drive(0, 4'b0000, 0);
    drive(0, 4'b0000, 0);

    // Reset in the middle of a grant on channel 3.
    drive(0, 4'b1000, 0);
    drive(0, 4'b1000, 0);
    drive(1, 4'b1111, 0);
    drive(0, 4'b1111, 0);
    drive(0, 4'b1111, 1);
    drive(0, 4'b0000, 0);
    drive(0, 4'b0000, 0);

    // Randomized traffic: sticky request patterns so that long holds and
    // timeouts occur, occasional done and rare resets.
    r_req = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r_req = 4'($urandom);
      drive(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
            r_req,
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
    end
    drive(0, 4'b0000, 0);

    active = 0;
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL time_limit actual=expired required=finished");
    $fatal(1);
  end

endmodule : tb_rr_arbiter_4ch
